ef_i2s_rx_mc: RTL and testbench

Parametrised master-mode I2S receiver: generates SCK/WS, deserialises 1–32-bit samples from one or both channels in Philips-I2S or left-justified framing, and buffers them in a depth-configurable FIFO for the bus wrapper. It is the successor to the fixed-depth, Philips-only receiver and adds framing mode, sign extension, overrun reporting and optional stereo-to-mono averaging.

---
 rtl/ef_i2s_pkg.sv | 32 +++
 rtl/ef_i2s_fifo.sv | 54 +++++
 rtl/ef_i2s_rx_mc.sv | 170 +++++++++++++++++
 tb/tb_ef_i2s_rx_mc.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ef_i2s_pkg.sv
// Shared constants and helpers for the ef_i2s master-mode receiver.
// Optional feature macro used by the top level: EF_I2S_AVG_EN (stereo averaging).
package ef_i2s_pkg;

  localparam logic I2S_PHILIPS = 1'b0;
  localparam logic I2S_LJ      = 1'b1;

  localparam logic [1:0] CH_NONE  = 2'b00;
  localparam logic [1:0] CH_LEFT  = 2'b01;
  localparam logic [1:0] CH_RIGHT = 2'b10;
  localparam logic [1:0] CH_BOTH  = 2'b11;

  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 64;

  // Widen an n-bit right-aligned sample (n = 1..32) to 32 bits, either
  // replicating its MSB or filling with zeros.
  function automatic logic [31:0] i2s_extend(input logic [31:0] v,
                                             input logic [5:0]  n,
                                             input logic        sgn);
    logic [31:0] r;
    logic [4:0]  idx;
    logic        fill;
    idx  = 5'(n - 6'd1);
    fill = sgn & v[idx];
    for (int i = 0; i < 32; i++) begin
      r[i] = (i < int'(n)) ? v[i] : fill;
    end
    return r;
  endfunction

endpackage

// File: rtl/ef_i2s_fifo.sv
// Synchronous first-word-fall-through FIFO with level/full/empty status.
// A write while full is accepted only when a pop happens in the same cycle.
module ef_i2s_fifo #(
  parameter int DW      = 32,
  parameter int FIFO_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr,
  input  logic [DW-1:0]     i_wdata,
  input  logic              i_rd,
  output logic [DW-1:0]     o_rdata,
  output logic [FIFO_AW:0]  o_level,
  output logic              o_full,
  output logic              o_empty
);

  logic [DW-1:0]      r_mem [2**FIFO_AW];
  logic [FIFO_AW-1:0] r_wp;
  logic [FIFO_AW-1:0] r_rp;
  logic [FIFO_AW:0]   r_level;
  logic               w_rd;
  logic               w_wr;

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == {1'b1, {FIFO_AW{1'b0}}});
  assign w_rd    = i_rd & ~o_empty;
  assign w_wr    = i_wr & (~o_full | w_rd);
  assign o_level = r_level;
  assign o_rdata = o_empty ? '0 : r_mem[r_rp];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage array; contents are only observed through the occupancy gate.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= i_wdata;
  end

endmodule

// File: rtl/ef_i2s_rx_mc.sv
// Master-mode I2S receiver: SCK/WS generation, per-channel deserialiser,
// sign/zero extension, overrun reporting and an output FWFT FIFO.
// Define EF_I2S_AVG_EN to build the optional stereo-to-mono averager.
module ef_i2s_rx_mc #(
  parameter int FIFO_AW = 4,
  parameter int DW      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sdi,
  output logic              sck,
  output logic              ws,
  input  logic [7:0]        sck_prescaler,
  input  logic [4:0]        sample_size,
  input  logic [1:0]        channels,
  input  logic              mode,
  input  logic              sign_ext,
  input  logic              fifo_rd,
  output logic [DW-1:0]     fifo_rdata,
  output logic [FIFO_AW:0]  fifo_level,
  input  logic [FIFO_AW:0]  fifo_level_threshold,
  output logic              fifo_level_above,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              overrun,
  input  logic              overrun_clr,
  input  logic              avg
);
  import ef_i2s_pkg::*;

  logic        r_run;
  logic [7:0]  r_pre;
  logic        r_sck;
  logic        r_ws;
  logic [5:0]  r_pos;      // frame position of the next SCK rising edge
  logic        r_mode;
  logic [4:0]  r_size;
  logic [31:0] r_shift;
  logic [5:0]  r_nbits;
  logic        r_cap_vld;
  logic        r_cap_ch;
  logic        r_overrun;

  logic        w_tick;
  logic        w_rise;
  logic [4:0]  w_slot;
  logic [4:0]  w_first;
  logic [5:0]  w_end;
  logic [4:0]  w_last;
  logic        w_in_win;
  logic [31:0] w_word;
  logic        w_ch_en;
  logic        w_push;
  logic [31:0] w_wdata;
  logic        w_drop;

  assign w_tick  = r_run & (r_pre >= sck_prescaler);
  assign w_rise  = en & w_tick & ~r_sck;
  assign w_slot  = r_pos[4:0];
  assign w_first = (r_mode == I2S_LJ) ? 5'd0 : 5'd1;
  assign w_end   = {1'b0, w_first} + {1'b0, r_size};
  // A window running past the channel's last slot is cut off there.
  assign w_last  = w_end[5] ? 5'd31 : w_end[4:0];
  assign w_in_win = (w_slot >= w_first) && (w_slot <= w_last);

  // Bit-clock generator, frame position, word select and per-frame config.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run     <= 1'b0;
      r_pre     <= '0;
      r_sck     <= 1'b0;
      r_ws      <= 1'b0;
      r_pos     <= '0;
      r_mode    <= I2S_PHILIPS;
      r_size    <= '0;
      r_cap_vld <= 1'b0;
    end else begin
      r_cap_vld <= 1'b0;
      if (!en) begin
        r_run <= 1'b0;
        r_pre <= '0;
        r_sck <= 1'b0;
        r_ws  <= 1'b0;
        r_pos <= '0;
      end else if (!r_run) begin
        r_run  <= 1'b1;
        r_mode <= mode;
        r_size <= sample_size;
      end else if (w_tick) begin
        r_pre <= '0;
        r_sck <= ~r_sck;
        if (!r_sck) begin
          r_pos <= r_pos + 6'd1;
          if (w_in_win && (w_slot == w_last)) r_cap_vld <= 1'b1;
        end else begin
          r_ws <= r_pos[5];
          if (r_ws && !r_pos[5]) begin
            r_mode <= mode;
            r_size <= sample_size;
          end
        end
      end else begin
        r_pre <= r_pre + 8'd1;
      end
    end
  end

  // Deserialiser: restart at the window's first slot, shift MSB first.
  always_ff @(posedge clk) begin
    if (w_rise && w_in_win) begin
      r_shift <= (w_slot == w_first) ? {31'd0, sdi} : {r_shift[30:0], sdi};
      if (w_slot == w_last) begin
        r_cap_ch <= r_pos[5];
        r_nbits  <= {1'b0, w_last} - {1'b0, w_first} + 6'd1;
      end
    end
  end

  assign w_word  = i2s_extend(r_shift, r_nbits, sign_ext);
  assign w_ch_en = r_cap_ch ? channels[1] : channels[0];

`ifdef EF_I2S_AVG_EN
  logic [31:0] r_hold;
  logic        w_avg_on;
  logic [32:0] w_sum;

  assign w_avg_on = avg && (channels == CH_BOTH);
  assign w_sum    = {sign_ext & r_hold[31], r_hold} + {sign_ext & w_word[31], w_word};
  assign w_push   = r_cap_vld & w_ch_en & ~(w_avg_on & ~r_cap_ch);
  assign w_wdata  = (w_avg_on && r_cap_ch) ? w_sum[32:1] : w_word;

  // Left sample is parked here until its right partner completes.
  always_ff @(posedge clk) begin
    if (r_cap_vld && !r_cap_ch) r_hold <= w_word;
  end
`else
  logic w_unused_avg;
  assign w_unused_avg = avg;
  assign w_push  = r_cap_vld & w_ch_en;
  assign w_wdata = w_word;
`endif

  // A full FIFO only loses the word when no pop frees a slot this cycle.
  assign w_drop = w_push & fifo_full & ~fifo_rd;

  // Sticky overrun flag; a new drop outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_overrun <= 1'b0;
    else        r_overrun <= (r_overrun & ~overrun_clr) | w_drop;
  end

  ef_i2s_fifo #(.DW(DW), .FIFO_AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr    (w_push),
    .i_wdata (w_wdata),
    .i_rd    (fifo_rd),
    .o_rdata (fifo_rdata),
    .o_level (fifo_level),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign sck              = r_sck;
  assign ws               = r_ws;
  assign overrun          = r_overrun;
  assign fifo_level_above = (fifo_level > fifo_level_threshold);

endmodule

// File: tb/tb_ef_i2s_rx_mc.sv
// Self-checking bench for ef_i2s_rx_mc: a codec model drives sdi frame by
// frame and a queue model predicts every FIFO word and status flag.
module tb_ef_i2s_rx_mc;
  localparam int FIFO_AW = 4;
  localparam int DEPTH   = 16;
  localparam int THR     = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              sdi = 1'b0;
  logic              sck, ws;
  logic [7:0]        sck_prescaler = 8'd0;
  logic [4:0]        sample_size = 5'd0;
  logic [1:0]        channels = 2'b00;
  logic              mode = 1'b0;
  logic              sign_ext = 1'b0;
  logic              fifo_rd = 1'b0;
  logic [31:0]       fifo_rdata;
  logic [FIFO_AW:0]  fifo_level;
  logic [FIFO_AW:0]  fifo_level_threshold = (FIFO_AW+1)'(THR);
  logic              fifo_level_above, fifo_empty, fifo_full, overrun;
  logic              overrun_clr = 1'b0;
  logic              avg = 1'b0;

  always #5 clk = ~clk;

  ef_i2s_rx_mc #(.FIFO_AW(FIFO_AW), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sdi(sdi), .sck(sck), .ws(ws),
    .sck_prescaler(sck_prescaler), .sample_size(sample_size),
    .channels(channels), .mode(mode), .sign_ext(sign_ext),
    .fifo_rd(fifo_rd), .fifo_rdata(fifo_rdata), .fifo_level(fifo_level),
    .fifo_level_threshold(fifo_level_threshold),
    .fifo_level_above(fifo_level_above), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .overrun(overrun), .overrun_clr(overrun_clr),
    .avg(avg)
  );

  int          n_chk = 0;
  int          n_err = 0;
  bit          tmo = 1'b0;
  logic [31:0] exp_q[$];
  bit          exp_ovr = 1'b0;
  int          c_mode, c_size, c_p;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // n-bit value widened to 32 bits by masking and OR-ing the upper ones.
  function automatic logic [31:0] ext_model(input logic [31:0] v, input int n, input bit sgn);
    longint unsigned mask;
    longint unsigned x;
    mask = (64'd1 << n) - 64'd1;
    x = {32'd0, v} & mask;
    if (sgn && ((x >> (n - 1)) & 64'd1) != 0) x = x | ~mask;
    return x[31:0];
  endfunction

  function automatic logic [31:0] avg_model(input logic [31:0] l, input logic [31:0] r, input bit sgn);
    longint a, b, s;
    a = sgn ? longint'($signed(l)) : longint'({32'd0, l});
    b = sgn ? longint'($signed(r)) : longint'({32'd0, r});
    s = (a + b) >>> 1;
    return s[31:0];
  endfunction

  function automatic void model_push(input logic [31:0] w);
    if (exp_q.size() < DEPTH) exp_q.push_back(w);
    else exp_ovr = 1'b1;
  endfunction

  // Wait for the next SCK rising edge; n = negedges of clk spent waiting.
  task automatic wait_rise(output int n);
    logic prev;
    bit   done;
    prev = sck;
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      n++;
      if (sck && !prev) done = 1'b1;
      else if (n > 2000) begin
        chk("sck_timeout", 32'd0, 32'd1);
        tmo = 1'b1;
        done = 1'b1;
      end
      prev = sck;
    end
  endtask

  // Codec side of one frame: window bits from L/R, random elsewhere.
  task automatic send_frame(input logic [31:0] l, input logic [31:0] r,
                            input int stop_at, input bit first);
    bit fb[64];
    int st, n, cyc;
    st = (c_mode == 1) ? 0 : 1;
    n  = c_size + 1;
    for (int p = 0; p < 64; p++) fb[p] = 1'($urandom_range(0, 1));
    for (int i = 0; i < n; i++) begin
      fb[st + i]      = l[n - 1 - i];
      fb[32 + st + i] = r[n - 1 - i];
    end
    for (int p = 0; p < 64; p++) begin
      if (p == stop_at) begin
        en = 1'b0;
        return;
      end
      sdi = fb[p];
      wait_rise(cyc);
      if (tmo) return;
      if (first && p == 0) chk("first_rise_latency", cyc, c_p + 2);
      if (first && p >= 1 && p <= 3) chk("sck_period", cyc, 2 * (c_p + 1));
      if ((p % 32) == 0 || (p % 32) == 31) chk("ws_slot", ws, (p >= 32));
    end
  endtask

  task automatic burst(input int md, input int sz, input int ps, input logic [1:0] ch,
                       input bit sgn, input bit av, input int nfr, input int stop_at,
                       input bit use_fix, input logic [31:0] fl, input logic [31:0] fr);
    logic [31:0] l, r, m;
    c_mode = md; c_size = sz; c_p = ps;
    mode = md[0]; sample_size = 5'(sz); sck_prescaler = 8'(ps);
    channels = ch; sign_ext = sgn; avg = av;
    m = (sz == 31) ? 32'hFFFF_FFFF : ((32'd1 << (sz + 1)) - 32'd1);
    en = 1'b1;
    for (int f = 0; f < nfr; f++) begin
      l = use_fix ? fl : ($urandom() & m);
      r = use_fix ? fr : ($urandom() & m);
      if (f == nfr - 1 && stop_at >= 0) begin
        send_frame(l, r, stop_at, (f == 0));
      end else begin
        send_frame(l, r, -1, (f == 0));
        if (av && ch == 2'b11) begin
          model_push(avg_model(ext_model(l, sz + 1, sgn), ext_model(r, sz + 1, sgn), sgn));
        end else begin
          if (ch[0]) model_push(ext_model(l, sz + 1, sgn));
          if (ch[1]) model_push(ext_model(r, sz + 1, sgn));
        end
      end
      if (tmo) break;
    end
    en = 1'b0;
    avg = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int cnt;
    cnt = exp_q.size();
    chk({tag, "_level"}, 32'(fifo_level), cnt);
    chk({tag, "_empty"}, fifo_empty, (cnt == 0));
    chk({tag, "_full"}, fifo_full, (cnt == DEPTH));
    chk({tag, "_overrun"}, overrun, exp_ovr);
    while (exp_q.size() > 0) begin
      chk({tag, "_above"}, fifo_level_above, (exp_q.size() > THR));
      chk({tag, "_rdata"}, fifo_rdata, exp_q.pop_front());
      fifo_rd = 1'b1;
      @(negedge clk);
      fifo_rd = 1'b0;
    end
    chk({tag, "_empty_after"}, fifo_empty, 1'b1);
    fifo_rd = 1'b1;
    @(negedge clk);
    fifo_rd = 1'b0;
    chk({tag, "_pop_on_empty_level"}, 32'(fifo_level), 32'd0);
    chk({tag, "_pop_on_empty_flag"}, fifo_empty, 1'b1);
  endtask

  initial begin
    // Reset state, held and released, then idle with en low.
    repeat (3) @(negedge clk);
    chk("rst_sck", sck, 1'b0);
    chk("rst_ws", ws, 1'b0);
    chk("rst_rdata", fifo_rdata, 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_empty", fifo_empty, 1'b1);
    chk("rst_full", fifo_full, 1'b0);
    chk("rst_above", fifo_level_above, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_sck", sck, 1'b0);
    chk("idle_ws", ws, 1'b0);

    // Clock timing with prescaler 4 (SCK period 10 clk).
    burst(1, 15, 4, 2'b11, 1'b0, 1'b0, 2, -1, 1'b0, 32'd0, 32'd0);
    drain("clk4");

    // Philips 18-bit, left only, sign- and zero-extended.
    burst(0, 17, 1, 2'b01, 1'b1, 1'b0, 1, -1, 1'b1, 32'h2A5A5, 32'h15A5A);
    chk("philips_sx_const", fifo_rdata, 32'hFFFE_A5A5);
    drain("philips_sx");
    burst(0, 17, 1, 2'b01, 1'b0, 1'b0, 1, -1, 1'b1, 32'h2A5A5, 32'h15A5A);
    chk("philips_zx_const", fifo_rdata, 32'h0002_A5A5);
    drain("philips_zx");

    // Left-justified 24-bit stereo.
    burst(1, 23, 2, 2'b11, 1'b0, 1'b0, 1, -1, 1'b1, 32'h123456, 32'h654321);
    chk("lj_left_const", fifo_rdata, 32'h0012_3456);
    drain("lj24");

    // Randomised configurations and data.
    for (int t = 0; t < 6; t++) begin
      int md, sz;
      md = int'($urandom_range(0, 1));
      sz = int'($urandom_range(0, md ? 31 : 30));
      burst(md, sz, int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'b0, int'($urandom_range(1, 3)), -1,
            1'b0, 32'd0, 32'd0);
      drain("rand");
    end

    // 17 samples into a 16-deep FIFO with no reads.
    burst(1, 7, 0, 2'b01, 1'b0, 1'b0, 17, -1, 1'b0, 32'd0, 32'd0);
    chk("ovf_full", fifo_full, 1'b1);
    chk("ovf_level", 32'(fifo_level), 32'd16);
    chk("ovf_overrun", overrun, 1'b1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    exp_ovr = 1'b0;
    chk("ovf_clr", overrun, 1'b0);
    drain("ovf");

    // en dropped mid-sample: partial word discarded, next one intact.
    burst(1, 23, 1, 2'b11, 1'b0, 1'b0, 1, 10, 1'b0, 32'd0, 32'd0);
    chk("abort_level", 32'(fifo_level), 32'd0);
    burst(1, 23, 1, 2'b11, 1'b1, 1'b0, 1, -1, 1'b0, 32'd0, 32'd0);
    drain("abort_next");

`ifdef EF_I2S_AVG_EN
    burst(1, 15, 1, 2'b11, 1'b1, 1'b1, 1, -1, 1'b1, 32'h0010, 32'hFFF0);
    chk("avg_const", fifo_rdata, 32'h0000_0000);
    drain("avg_fix");
    burst(0, 15, 1, 2'b11, 1'b1, 1'b1, 2, -1, 1'b0, 32'd0, 32'd0);
    drain("avg_rand");
`endif

    // Asynchronous reset in the middle of a running frame.
    burst(1, 7, 1, 2'b01, 1'b0, 1'b0, 1, -1, 1'b0, 32'd0, 32'd0);
    mode = 1'b1;
    en = 1'b1;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_sck", sck, 1'b0);
    chk("midrst_ws", ws, 1'b0);
    chk("midrst_level", 32'(fifo_level), 32'd0);
    chk("midrst_empty", fifo_empty, 1'b1);
    chk("midrst_rdata", fifo_rdata, 32'd0);
    exp_q.delete();
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
